legv8_fetch_branch_unit: RTL and testbench

Parametrised instruction-fetch and branch-resolution unit for the LEGv8 datapath. It owns the PC and runs a ready/valid handshake with a variable-latency instruction memory. It decodes B, CBZ and CBNZ itself and computes the next PC (PC+4, or PC + sign-extended offset << 2), including the branch adder, shift-left-2, PC-source mux and branch AND gate. It sits between instruction memory and the decoder/register file, and keeps retired-instruction and taken-branch counters.

---
 rtl/legv8_fetch_branch_unit.sv | 160 ++++++++++++++++
 tb/tb_legv8_fetch_branch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_fetch_branch_unit.sv
// LEGv8 fetch and branch-resolution unit: owns the PC, fetches over a
// ready/valid memory handshake and resolves B, CBZ and CBNZ locally.
module legv8_fetch_branch_unit #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              IReq,
  output logic [ADDR_W-1:0] IAddr,
  input  logic              IReady,
  input  logic [31:0]       InstrIn,
  output logic              InstrValid,
  output logic [31:0]       InstrOut,
  output logic [ADDR_W-1:0] PCOut,
  input  logic              InstrAccept,
  input  logic              ZeroValid,
  input  logic              Zero,
  output logic              BranchTaken,
  output logic [CNT_W-1:0]  RetiredCount,
  output logic [CNT_W-1:0]  TakenCount
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    RESOLVE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pcout_q, pcout_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [CNT_W-1:0]  tkn_q, tkn_d;
  logic              bt_q, bt_d;

  logic              is_b;
  logic              is_cb;
  logic              is_cbnz;
  logic              cb_taken;
  logic [ADDR_W-1:0] off_b;
  logic [ADDR_W-1:0] off_cb;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_tgt_b;
  logic [ADDR_W-1:0] pc_tgt_cb;
  logic [CNT_W-1:0]  ret_inc;
  logic [CNT_W-1:0]  tkn_inc;

  assign is_b    = (ir_q[31:26] == 6'b000101);
  assign is_cb   = (ir_q[31:25] == 7'b1011010);
  assign is_cbnz = ir_q[24];

  // Signed size casts sign-extend (or truncate) the scaled immediates
  // to the PC width, so all target arithmetic wraps modulo 2^ADDR_W.
  assign off_b  = ADDR_W'($signed({ir_q[25:0], 2'b00}));
  assign off_cb = ADDR_W'($signed({ir_q[23:5], 2'b00}));

  assign pc_seq    = pc_q + ADDR_W'(4);
  assign pc_tgt_b  = pc_q + off_b;
  assign pc_tgt_cb = pc_q + off_cb;

  assign ret_inc = ret_q + CNT_W'(1);
  assign tkn_inc = tkn_q + CNT_W'(1);

  assign cb_taken = is_cbnz ? ~Zero : Zero;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcout_d = pcout_q;
    ir_d    = ir_q;
    ret_d   = ret_q;
    tkn_d   = tkn_q;
    bt_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (IReady) begin
          ir_d    = InstrIn;
          pcout_d = pc_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (InstrAccept) begin
          unique case (1'b1)
            is_b: begin
              pc_d    = pc_tgt_b;
              bt_d    = 1'b1;
              ret_d   = ret_inc;
              tkn_d   = tkn_inc;
              state_d = FETCH;
            end
            is_cb: begin
              state_d = RESOLVE;
            end
            default: begin
              pc_d    = pc_seq;
              ret_d   = ret_inc;
              state_d = FETCH;
            end
          endcase
        end
      end
      RESOLVE: begin
        if (ZeroValid) begin
          ret_d   = ret_inc;
          state_d = FETCH;
          if (cb_taken) begin
            pc_d  = pc_tgt_cb;
            bt_d  = 1'b1;
            tkn_d = tkn_inc;
          end else begin
            pc_d  = pc_seq;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pcout_q <= RESET_PC;
      ir_q    <= '0;
      ret_q   <= '0;
      tkn_q   <= '0;
      bt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcout_q <= pcout_d;
      ir_q    <= ir_d;
      ret_q   <= ret_d;
      tkn_q   <= tkn_d;
      bt_q    <= bt_d;
    end
  end

  // Registered branch pulse lines up with the first cycle the
  // new target is on IAddr.
  assign IReq         = (state_q == FETCH);
  assign InstrValid   = (state_q == ISSUE);
  assign IAddr        = pc_q;
  assign InstrOut     = ir_q;
  assign PCOut        = pcout_q;
  assign BranchTaken  = bt_q;
  assign RetiredCount = ret_q;
  assign TakenCount   = tkn_q;

endmodule

// File: tb/tb_legv8_fetch_branch_unit.sv
// Bench for legv8_fetch_branch_unit: directed scenarios plus random
// instruction streams against a per-instruction architectural model.
module tb_legv8_fetch_branch_unit;

  localparam int            AW     = 16;
  localparam int            CW     = 4;
  localparam logic [AW-1:0] RST_PC = 16'h0100;
  localparam logic [31:0]   W_ADD  = 32'h8B020020;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          IReq;
  logic [AW-1:0] IAddr;
  logic          IReady;
  logic [31:0]   InstrIn;
  logic          InstrValid;
  logic [31:0]   InstrOut;
  logic [AW-1:0] PCOut;
  logic          InstrAccept;
  logic          ZeroValid;
  logic          Zero;
  logic          BranchTaken;
  logic [CW-1:0] RetiredCount;
  logic [CW-1:0] TakenCount;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] m_pc;
  logic [CW-1:0] m_ret;
  logic [CW-1:0] m_tkn;
  logic          m_bt;
  logic [31:0]   cur_w;

  legv8_fetch_branch_unit #(
    .ADDR_W  (AW),
    .RESET_PC(RST_PC),
    .CNT_W   (CW)
  ) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .IReq        (IReq),
    .IAddr       (IAddr),
    .IReady      (IReady),
    .InstrIn     (InstrIn),
    .InstrValid  (InstrValid),
    .InstrOut    (InstrOut),
    .PCOut       (PCOut),
    .InstrAccept (InstrAccept),
    .ZeroValid   (ZeroValid),
    .Zero        (Zero),
    .BranchTaken (BranchTaken),
    .RetiredCount(RetiredCount),
    .TakenCount  (TakenCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [AW-1:0] sext_off(input logic [31:0] imm,
                                             input int bits);
    longint v;
    v = longint'(imm);
    if (imm[bits-1]) v = v - (longint'(1) << bits);
    return AW'(v * 4);
  endfunction

  function automatic logic w_is_b(input logic [31:0] w);
    return w[31:26] == 6'b000101;
  endfunction

  function automatic logic w_is_cb(input logic [31:0] w);
    return w[31:25] == 7'b1011010;
  endfunction

  function automatic logic [31:0] b_to(input logic [AW-1:0] from,
                                       input logic [AW-1:0] to);
    logic signed [AW-1:0] d;
    d = to - from;
    return {6'b000101, 26'(d >>> 2)};
  endfunction

  task automatic do_fetch(input logic [31:0] w, input int rdly);
    for (int i = 0; i <= rdly; i++) begin
      chk("fetch_ireq", IReq, 1);
      chk("fetch_iaddr", IAddr, m_pc);
      chk("fetch_ivld", InstrValid, 0);
      chk("fetch_ret", RetiredCount, m_ret);
      chk("fetch_tkn", TakenCount, m_tkn);
      if (i > 0) chk("fetch_bt", BranchTaken, 0);
      IReady      = (i == rdly);
      InstrIn     = (i == rdly) ? w : $urandom;
      InstrAccept = 1'($urandom);
      ZeroValid   = 1'($urandom);
      Zero        = 1'($urandom);
      step();
    end
    IReady      = 1'b0;
    InstrAccept = 1'b0;
    ZeroValid   = 1'b0;
    cur_w       = w;
  endtask

  task automatic do_issue(input int adly);
    for (int i = 0; i <= adly; i++) begin
      chk("iss_ivld", InstrValid, 1);
      chk("iss_ir", InstrOut, cur_w);
      chk("iss_pcout", PCOut, m_pc);
      chk("iss_ireq", IReq, 0);
      chk("iss_bt", BranchTaken, 0);
      chk("iss_ret", RetiredCount, m_ret);
      IReady      = 1'($urandom);
      InstrIn     = $urandom;
      ZeroValid   = 1'($urandom);
      Zero        = 1'($urandom);
      InstrAccept = (i == adly);
      step();
    end
    InstrAccept = 1'b0;
    IReady      = 1'b0;
    ZeroValid   = 1'b0;
    if (w_is_b(cur_w)) begin
      m_pc  = m_pc + sext_off({6'd0, cur_w[25:0]}, 26);
      m_ret = m_ret + 1'b1;
      m_tkn = m_tkn + 1'b1;
      m_bt  = 1'b1;
    end else if (!w_is_cb(cur_w)) begin
      m_pc  = m_pc + 16'd4;
      m_ret = m_ret + 1'b1;
      m_bt  = 1'b0;
    end
  endtask

  task automatic do_resolve(input int zdly, input logic z);
    logic taken;
    for (int i = 0; i <= zdly; i++) begin
      chk("res_ivld", InstrValid, 0);
      chk("res_ireq", IReq, 0);
      chk("res_iaddr", IAddr, m_pc);
      chk("res_bt", BranchTaken, 0);
      chk("res_ret", RetiredCount, m_ret);
      ZeroValid   = (i == zdly);
      Zero        = (i == zdly) ? z : 1'($urandom);
      IReady      = 1'($urandom);
      InstrAccept = 1'($urandom);
      step();
    end
    ZeroValid   = 1'b0;
    IReady      = 1'b0;
    InstrAccept = 1'b0;
    // CBZ is opcode 0xB4, CBNZ 0xB5
    taken = (cur_w[31:24] == 8'hB4) ? z : !z;
    if (taken) begin
      m_pc  = m_pc + sext_off({13'd0, cur_w[23:5]}, 19);
      m_tkn = m_tkn + 1'b1;
    end else begin
      m_pc = m_pc + 16'd4;
    end
    m_ret = m_ret + 1'b1;
    m_bt  = taken;
  endtask

  task automatic post_check();
    chk("post_bt", BranchTaken, m_bt);
    chk("post_ireq", IReq, 1);
    chk("post_iaddr", IAddr, m_pc);
    chk("post_ivld", InstrValid, 0);
    chk("post_ret", RetiredCount, m_ret);
    chk("post_tkn", TakenCount, m_tkn);
  endtask

  task automatic run_instr(input logic [31:0] w, input int rdly,
                           input int adly, input int zdly, input logic z);
    do_fetch(w, rdly);
    do_issue(adly);
    if (w_is_cb(w)) do_resolve(zdly, z);
    post_check();
  endtask

  // Reset pulse with every other input active; then one IDLE cycle
  // with noise, then FETCH at the reset PC.
  task automatic do_reset();
    Reset       = 1'b1;
    ZeroValid   = 1'b1;
    Zero        = 1'b1;
    InstrAccept = 1'b1;
    IReady      = 1'b1;
    InstrIn     = W_ADD;
    step();
    Reset = 1'b0;
    m_pc  = RST_PC;
    m_ret = '0;
    m_tkn = '0;
    m_bt  = 1'b0;
    chk("rst_ireq", IReq, 0);
    chk("rst_ivld", InstrValid, 0);
    chk("rst_iaddr", IAddr, RST_PC);
    chk("rst_ir", InstrOut, 0);
    chk("rst_pcout", PCOut, RST_PC);
    chk("rst_bt", BranchTaken, 0);
    chk("rst_ret", RetiredCount, 0);
    chk("rst_tkn", TakenCount, 0);
    step();
    IReady      = 1'b0;
    InstrAccept = 1'b0;
    ZeroValid   = 1'b0;
    chk("rst_fetch_ireq", IReq, 1);
    chk("rst_fetch_iaddr", IAddr, RST_PC);
    chk("rst_fetch_bt", BranchTaken, 0);
  endtask

  initial begin
    logic [31:0] w;
    int k;
    Reset       = 1'b1;
    IReady      = 1'b0;
    InstrIn     = '0;
    InstrAccept = 1'b0;
    ZeroValid   = 1'b0;
    Zero        = 1'b0;
    step();
    do_reset();

    repeat (3) run_instr(W_ADD, 0, 0, 0, 0);
    chk("seq_iaddr", IAddr, 16'h010C);
    chk("seq_ret", RetiredCount, 3);
    chk("seq_tkn", TakenCount, 0);

    run_instr(b_to(m_pc, 16'h0200), 0, 0, 0, 0);
    run_instr({6'b000101, 26'h3FFFFFE}, 0, 0, 0, 0);
    chk("b_back_iaddr", IAddr, 16'h01F8);
    chk("b_back_bt", BranchTaken, 1);
    run_instr(W_ADD, 1, 0, 0, 0);

    run_instr(b_to(m_pc, 16'h0040), 0, 0, 0, 0);
    run_instr({8'hB4, 19'd4, 5'd3}, 0, 0, 0, 1);
    chk("cbz_t", IAddr, 16'h0050);
    run_instr(b_to(m_pc, 16'h0040), 0, 0, 0, 0);
    run_instr({8'hB4, 19'd4, 5'd3}, 0, 0, 0, 0);
    chk("cbz_nt", IAddr, 16'h0044);
    run_instr(b_to(m_pc, 16'h0040), 0, 0, 0, 0);
    run_instr({8'hB5, 19'd4, 5'd3}, 0, 0, 0, 0);
    chk("cbnz_t", IAddr, 16'h0050);
    run_instr({8'hB4, 19'd4, 5'd3}, 0, 0, 5, 1);

    run_instr(W_ADD, 4, 3, 0, 0);

    do_fetch({8'hB4, 19'd4, 5'd3}, 0);
    do_issue(0);
    do_reset();
    do_fetch(W_ADD, 0);
    do_reset();
    run_instr(W_ADD, 0, 0, 0, 0);

    run_instr(b_to(m_pc, 16'hFFFC), 0, 0, 0, 0);
    chk("wrap_pre", IAddr, 16'hFFFC);
    run_instr({6'b000101, 26'd1}, 0, 0, 0, 0);
    chk("wrap_pc", IAddr, 16'h0000);

    do_reset();
    repeat (17) run_instr(W_ADD, 0, 0, 0, 0);
    chk("ret_wrap17", RetiredCount, 1);

    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 3);
      unique case (k)
        0: begin
          w = $urandom;
          if (w_is_b(w) || w_is_cb(w)) w = W_ADD;
        end
        1: w = {6'b000101, 26'($urandom)};
        2: w = {8'hB4, 24'($urandom)};
        default: w = {8'hB5, 24'($urandom)};
      endcase
      run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 5), 1'($urandom));
      if (n == 120) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
